// File: rtl/pipe_ctrl_stage.sv
// pipe_ctrl_stage: one pipeline stage for a control bundle with valid/ready
// handshaking on both sides. With SKID=1 a second (skid) register lets
// in_ready come purely from registered state, so the ready path is cut
// between stages. With SKID=0 the stage is a single register whose in_ready
// looks through to out_ready. A synchronous flush squashes every held beat.
module pipe_ctrl_stage #(
    parameter int unsigned      WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               SKID      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    // Occupancy state; the encoding doubles as the number of beats held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] head_q,  head_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic [1:0]       count_q, count_d;

    logic             accept;
    logic             emit;

    // The head register is the output; it holds RESET_VAL whenever empty.
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = head_q;
    assign count     = count_q;

    // in_ready is forced low while reset is asserted so nothing can be taken
    // in while the stage is being cleared.
    if (SKID != 0) begin : g_skid
        assign in_ready = reset && (state_q != ST_TWO);
    end else begin : g_noskid
        assign in_ready = reset && ((state_q == ST_EMPTY) || out_ready);
    end

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // Next-state logic: flush beats everything; otherwise move beats between
    // input, skid and head according to which handshakes fire this cycle.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;

        if (flush) begin
            // A beat emitted this cycle is already delivered; an accepted
            // beat and anything still held are dropped.
            state_d = ST_EMPTY;
            head_d  = RESET_VAL;
            count_d = 2'd0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_d  = in_data;
                        state_d = ST_ONE;
                        count_d = 2'd1;
                    end
                end

                ST_ONE: begin
                    if (accept && emit) begin
                        // Pass-through: new beat replaces the departing head.
                        head_d = in_data;
                    end else if (emit) begin
                        head_d  = RESET_VAL;
                        state_d = ST_EMPTY;
                        count_d = 2'd0;
                    end else if (accept && (SKID != 0)) begin
                        // Downstream stalled: park the new beat behind head.
                        skid_d  = in_data;
                        state_d = ST_TWO;
                        count_d = 2'd2;
                    end
                end

                ST_TWO: begin
                    // in_ready is low here, so only an emit can change state.
                    if (emit) begin
                        head_d  = skid_q;
                        state_d = ST_ONE;
                        count_d = 2'd1;
                    end
                end

                default: begin
                    state_d = ST_EMPTY;
                    head_d  = RESET_VAL;
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // Control state and the visible head register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            head_q  <= RESET_VAL;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Skid data register: never observed unless the state says it is valid,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Bench for pipe_ctrl_stage: one SKID=1 and one SKID=0 instance share the
// same stimulus. A queue-level model per instance (list of accepted beats
// with read/write indices) predicts ready, valid, data and count.
module tb_pipe_ctrl_stage;

    localparam int         N   = 8192;
    localparam logic [2:0] RV1 = 3'b000;
    localparam logic [2:0] RV0 = 3'b011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic [2:0] in_data;
    logic       flush;
    logic       out_ready;

    logic [1:0]      in_ready_v;
    logic [1:0]      out_valid_v;
    logic [1:0][2:0] out_data_v;
    logic [1:0][1:0] count_v;

    pipe_ctrl_stage #(.WIDTH(3), .RESET_VAL(RV1), .SKID(1)) u_skid1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[1]),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid_v[1]),
        .out_ready (out_ready),
        .out_data  (out_data_v[1]),
        .count     (count_v[1])
    );

    pipe_ctrl_stage #(.WIDTH(3), .RESET_VAL(RV0), .SKID(0)) u_skid0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[0]),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid_v[0]),
        .out_ready (out_ready),
        .out_data  (out_data_v[0]),
        .count     (count_v[0])
    );

    // Scoreboard: every accepted beat is appended; rd points at the head.
    logic [2:0] sb [0:1][0:N-1];
    int         wr [0:1] = '{0, 0};
    int         rd [0:1] = '{0, 0};
    bit         acc [0:1] = '{0, 0};
    bit         em  [0:1] = '{0, 0};

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [2:0] rv(input int k);
        return (k == 1) ? RV1 : RV0;
    endfunction

    task automatic check(input string nm, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut_skid%0d: got %0h expected %0h at t=%0t",
                     nm, k, act, exp, $time);
        end
    endtask

    // Monitor: compare the presented outputs against the model, and note
    // which handshakes the model says fire before the coming edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int         lvl;
            logic       exp_rdy;
            logic [2:0] exp_data;
            lvl = wr[k] - rd[k];
            if (k == 1) exp_rdy = reset && (lvl < 2);
            else        exp_rdy = reset && ((lvl == 0) || out_ready);
            exp_data = (lvl > 0) ? sb[k][rd[k]] : rv(k);
            check("in_ready",  k, 32'(in_ready_v[k]),  32'(exp_rdy));
            check("out_valid", k, 32'(out_valid_v[k]), 32'(lvl > 0));
            check("out_data",  k, 32'(out_data_v[k]),  32'(exp_data));
            check("count",     k, 32'(count_v[k]),     32'(lvl));
            acc[k] = in_valid && exp_rdy;
            em[k]  = reset && (lvl > 0) && out_ready;
        end
    end

    // Model update at the edge: emits leave, flush drops everything held
    // plus any accept, otherwise an accepted beat is appended.
    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                rd[k] = wr[k];
            end else begin
                if (em[k]) rd[k] = rd[k] + 1;
                if (flush) begin
                    rd[k] = wr[k];
                end else if (acc[k]) begin
                    sb[k][wr[k]] = in_data;
                    wr[k] = wr[k] + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] d,
                       input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Pulse reset low between edges and confirm outputs clear immediately.
    task automatic reset_pulse();
        reset = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check("async_out_valid", k, 32'(out_valid_v[k]), 32'd0);
            check("async_count",     k, 32'(count_v[k]),     32'd0);
            check("async_in_ready",  k, 32'(in_ready_v[k]),  32'd0);
            check("async_out_data",  k, 32'(out_data_v[k]),  32'(rv(k)));
        end
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        drv(1'b0, 3'd0, 1'b0, 1'b0);
        repeat (3) step();
        reset = 1'b1;

        // Single beat through an empty stage.
        step(); drv(1'b1, 3'b101, 1'b1, 1'b0);
        step(); drv(1'b0, 3'b000, 1'b1, 1'b0);
        step();

        // Stall downstream, fill, then drain in order.
        drv(1'b1, 3'b001, 1'b0, 1'b0);
        step(); drv(1'b1, 3'b010, 1'b0, 1'b0);
        step(); drv(1'b0, 3'b111, 1'b0, 1'b0);
        step(); drv(1'b0, 3'b111, 1'b1, 1'b0);
        repeat (3) step();

        // Eight back-to-back beats with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 3'(i), 1'b1, 1'b0);
            step();
        end
        drv(1'b0, 3'b000, 1'b1, 1'b0);
        repeat (2) step();

        // Fill to two, then flush while a new beat is offered.
        drv(1'b1, 3'b011, 1'b0, 1'b0);
        step(); drv(1'b1, 3'b100, 1'b0, 1'b0);
        step(); drv(1'b1, 3'b111, 1'b0, 1'b1);
        step(); drv(1'b0, 3'b000, 1'b1, 1'b0);
        repeat (3) step();

        // Single-register pass-through with a held beat and ready downstream.
        drv(1'b1, 3'b011, 1'b0, 1'b0);
        step(); drv(1'b1, 3'b110, 1'b1, 1'b0);
        step(); drv(1'b0, 3'b000, 1'b1, 1'b0);
        repeat (2) step();

        // Reset between edges while holding two beats.
        drv(1'b1, 3'b001, 1'b0, 1'b0);
        step(); drv(1'b1, 3'b010, 1'b0, 1'b0);
        step(); drv(1'b0, 3'b000, 1'b0, 1'b0);
        step(); reset_pulse(); drv(1'b0, 3'b000, 1'b1, 1'b0);
        repeat (2) step();

        // Random traffic with occasional flush and reset pulses.
        for (int i = 0; i < 600; i++) begin
            step();
            drv($urandom_range(0, 9) < 7, 3'($urandom),
                $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 79) == 0) reset_pulse();
        end

        // Drain: everything accepted must come out, nothing extra.
        step(); drv(1'b0, 3'b000, 1'b1, 1'b0);
        repeat (6) step();
        for (int k = 0; k < 2; k++)
            check("drain_level", k, 32'(wr[k] - rd[k]), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
